// File: rtl/alu_iter_if.sv
// Request/response bundle for the iterative ALU: operation request in,
// registered result, multiply high half and condition codes out.
interface alu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] y_out;
    logic             n;
    logic             z;
    logic             v;
    logic             c;
    logic             illegal;

    modport master (
        output start, opcode, a_in, b_in,
        input  ready, done, result, y_out, n, z, v, c, illegal
    );

    modport slave (
        input  start, opcode, a_in, b_in,
        output ready, done, result, y_out, n, z, v, c, illegal
    );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier taking WIDTH cycles, with SPARC-style condition codes.
module alu_iter #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    acc_q, mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [SW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q, y_q;
    logic             n_q, z_q, v_q, c_q;
    logic             done_q, illegal_q;

    logic accept, start_mul, mul_last;

    assign accept    = (state_q == StIdle) && bus.start;
    assign start_mul = MUL_EN && !bus.opcode[5] && (bus.opcode[3:1] == 3'b101);
    assign mul_last  = (state_q == StMul) && (cnt_q == SW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = start_mul ? StMul : StExec;
            StExec:  state_d = StIdle;
            StMul:   if (mul_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Single-cycle datapath, evaluated while in StExec on the latched operands.
    logic [WIDTH:0]   sum, diff;
    logic             cin;
    logic [SW-1:0]    amt;
    logic [WIDTH-1:0] ex_res;
    logic             ex_wr, ex_ill, ex_v, ex_c;

    always_comb begin
        cin    = op_q[3] & c_q;
        sum    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
        diff   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
        amt    = b_q[SW-1:0];
        ex_res = '0;
        ex_wr  = 1'b0;
        ex_ill = 1'b0;
        ex_v   = 1'b0;
        ex_c   = 1'b0;
        if (!op_q[5]) begin
            ex_wr = op_q[4];
            case (op_q[3:0])
                4'b0000, 4'b1000: begin
                    ex_res = sum[WIDTH-1:0];
                    ex_c   = sum[WIDTH];
                    ex_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (ex_res[WIDTH-1] != a_q[WIDTH-1]);
                end
                4'b0100, 4'b1100: begin
                    ex_res = diff[WIDTH-1:0];
                    ex_c   = diff[WIDTH];
                    ex_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (ex_res[WIDTH-1] != a_q[WIDTH-1]);
                end
                4'b0001: ex_res = a_q & b_q;
                4'b0101: ex_res = a_q & ~b_q;
                4'b0010: ex_res = a_q | b_q;
                4'b0110: ex_res = a_q | ~b_q;
                4'b0011: ex_res = a_q ^ b_q;
                4'b0111: ex_res = ~(a_q ^ b_q);
                // Multiply codes only land here when the multiplier is disabled.
                default: begin
                    ex_ill = 1'b1;
                    ex_wr  = 1'b0;
                end
            endcase
        end else begin
            case (op_q[4:0])
                5'b00101: ex_res = a_q << amt;
                5'b00110: ex_res = a_q >> amt;
                5'b00111: ex_res = $signed(a_q) >>> amt;
                5'b01010: ex_res = b_q << 10;
                default:  ex_ill = 1'b1;
            endcase
        end
    end

    // Shift-add step; for SMUL the multiplier MSB carries negative weight.
    logic [PW-1:0] addend, acc_d;

    always_comb begin
        addend = mplier_q[0] ? mcand_q : '0;
        acc_d  = (op_q[0] && mul_last) ? acc_q - addend : acc_q + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            y_q       <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            v_q       <= 1'b0;
            c_q       <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (accept) begin
                op_q     <= bus.opcode;
                a_q      <= bus.a_in;
                b_q      <= bus.b_in;
                acc_q    <= '0;
                mcand_q  <= bus.opcode[0] ? {{WIDTH{bus.a_in[WIDTH-1]}}, bus.a_in}
                                          : {{WIDTH{1'b0}}, bus.a_in};
                mplier_q <= bus.b_in;
                cnt_q    <= '0;
            end
            if (state_q == StExec) begin
                done_q    <= 1'b1;
                illegal_q <= ex_ill;
                result_q  <= ex_res;
                if (ex_wr) begin
                    n_q <= ex_res[WIDTH-1];
                    z_q <= (ex_res == '0);
                    v_q <= ex_v;
                    c_q <= ex_c;
                end
            end
            if (state_q == StMul) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (mul_last) begin
                    done_q   <= 1'b1;
                    result_q <= acc_d[WIDTH-1:0];
                    y_q      <= acc_d[PW-1:WIDTH];
                    if (op_q[4]) begin
                        n_q <= acc_d[WIDTH-1];
                        z_q <= (acc_d[WIDTH-1:0] == '0);
                        v_q <= 1'b0;
                        c_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.ready   = (state_q == StIdle);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.y_out   = y_q;
    assign bus.n       = n_q;
    assign bus.z       = z_q;
    assign bus.v       = v_q;
    assign bus.c       = c_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_iter.sv
// Randomized self-checking bench for alu_iter: a 32-bit instance with the
// multiplier and an 8-bit instance without it, checked against an arithmetic model.
module tb_alu_iter;
    logic clk = 1'b0;
    logic rst;
    bit   sel;

    always #5 clk = ~clk;

    alu_iter_if #(.WIDTH(32)) bus ();
    alu_iter_if #(.WIDTH(8))  bus8 ();

    alu_iter #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    alu_iter #(.WIDTH(8),  .MUL_EN(1'b0)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    logic        drv_start;
    logic [5:0]  drv_op;
    logic [63:0] drv_a, drv_b;

    assign bus.start   = drv_start & !sel;
    assign bus.opcode  = drv_op;
    assign bus.a_in    = drv_a[31:0];
    assign bus.b_in    = drv_b[31:0];
    assign bus8.start  = drv_start & sel;
    assign bus8.opcode = drv_op;
    assign bus8.a_in   = drv_a[7:0];
    assign bus8.b_in   = drv_b[7:0];

    logic        obs_ready, obs_done, obs_ill;
    logic [63:0] obs_res, obs_y;
    logic [3:0]  obs_flags;

    always_comb begin
        if (sel) begin
            obs_ready = bus8.ready;
            obs_done  = bus8.done;
            obs_ill   = bus8.illegal;
            obs_res   = {56'b0, bus8.result};
            obs_y     = {56'b0, bus8.y_out};
            obs_flags = {bus8.n, bus8.z, bus8.v, bus8.c};
        end else begin
            obs_ready = bus.ready;
            obs_done  = bus.done;
            obs_ill   = bus.illegal;
            obs_res   = {32'b0, bus.result};
            obs_y     = {32'b0, bus.y_out};
            obs_flags = {bus.n, bus.z, bus.v, bus.c};
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          w;
    bit          mul_en;
    int          last_lat;
    logic [63:0] m_res, m_y;
    logic [3:0]  m_fl;

    logic [5:0] legal_ops [16] = '{6'b000000, 6'b001000, 6'b000100, 6'b001100,
                                   6'b000001, 6'b000101, 6'b000010, 6'b000110,
                                   6'b000011, 6'b000111, 6'b001010, 6'b001011,
                                   6'b100101, 6'b100110, 6'b100111, 6'b101010};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values; fl = {n,z,v,c}.
    function automatic void model(input int wd, input bit me, input logic [5:0] op,
                                  input logic [63:0] a, input logic [63:0] b, input bit cf,
                                  output logic [63:0] res, output logic [63:0] hi,
                                  output bit wf, output bit wy, output bit ill,
                                  output logic [3:0] fl, output int lat);
        logic [63:0] mask, full, prod;
        longint      sa, sb, sres, lim;
        bit          cin, v, c;
        int          amt;
        mask = (64'd1 << wd) - 64'd1;
        lim  = longint'(1) << (wd - 1);
        sa   = a[wd-1] ? longint'(a) - (longint'(1) << wd) : longint'(a);
        sb   = b[wd-1] ? longint'(b) - (longint'(1) << wd) : longint'(b);
        amt  = int'(b[5:0]) & (wd - 1);
        cin  = op[3] & cf;
        res  = '0;
        hi   = '0;
        wf   = op[4];
        wy   = 1'b0;
        ill  = 1'b0;
        v    = 1'b0;
        c    = 1'b0;
        lat  = 2;
        casez (op)
            6'b0?0000, 6'b0?1000: begin
                full = a + b + 64'(cin);
                res  = full & mask;
                c    = full > mask;
                sres = sa + sb + longint'(cin);
                v    = (sres >= lim) || (sres < -lim);
            end
            6'b0?0100, 6'b0?1100: begin
                res = (a - b - 64'(cin)) & mask;
                c   = a < b + 64'(cin);
                v   = (a[wd-1] != b[wd-1]) && (res[wd-1] != a[wd-1]);
            end
            6'b0?0001: res = a & b;
            6'b0?0101: res = a & ~b & mask;
            6'b0?0010: res = a | b;
            6'b0?0110: res = (a | ~b) & mask;
            6'b0?0011: res = a ^ b;
            6'b0?0111: res = ~(a ^ b) & mask;
            6'b0?1010, 6'b0?1011: begin
                if (me) begin
                    prod = op[0] ? 64'(sa * sb) : a * b;
                    res  = prod & mask;
                    hi   = (prod >> wd) & mask;
                    wy   = 1'b1;
                    lat  = wd + 1;
                end else begin
                    ill = 1'b1;
                end
            end
            6'b100101: res = (a << amt) & mask;
            6'b100110: res = a >> amt;
            6'b100111: res = 64'(sa >>> amt) & mask;
            6'b101010: res = (b << 10) & mask;
            default:   ill = 1'b1;
        endcase
        if (ill) begin
            res = '0;
            wf  = 1'b0;
        end
        fl = {res[wd-1], res == 64'd0, v, c};
    endfunction

    function automatic logic [63:0] pick_val(input int wd);
        logic [63:0] mask, val;
        mask = (64'd1 << wd) - 64'd1;
        case ($urandom_range(0, 7))
            0:       val = '0;
            1:       val = mask;
            2:       val = 64'd1 << (wd - 1);
            3:       val = (64'd1 << (wd - 1)) - 64'd1;
            default: val = {$urandom, $urandom};
        endcase
        return val & mask;
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        if ($urandom_range(0, 9) == 0) return 6'($urandom);
        op = legal_ops[$urandom_range(0, 15)];
        if (!op[5]) op[4] = 1'($urandom_range(0, 1));
        return op;
    endfunction

    // Starts at a negedge with the DUT ready; returns at the negedge where done is high.
    task automatic do_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit noisy);
        logic [63:0] e_res, e_hi;
        logic [3:0]  e_fl;
        bit          wf, wy, ill, got;
        int          e_lat, lat;
        model(w, mul_en, op, a, b, m_fl[0], e_res, e_hi, wf, wy, ill, e_fl, e_lat);
        drv_start = 1'b1;
        drv_op    = op;
        drv_a     = a;
        drv_b     = b;
        @(posedge clk);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (obs_done) begin
                got = 1'b1;
                break;
            end
            // Busy: stray starts and operand churn must not disturb the operation.
            drv_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            drv_op    = 6'($urandom);
            drv_a     = {$urandom, $urandom};
            drv_b     = {$urandom, $urandom};
            @(posedge clk);
            lat++;
        end
        drv_start = 1'b0;
        last_lat  = lat;
        if (!got) begin
            check("done_timeout", 64'(got), 64'd1);
            return;
        end
        m_res = e_res;
        if (wy) m_y = e_hi;
        if (wf) m_fl = e_fl;
        check("latency", 64'(lat), 64'(e_lat));
        check("result", obs_res, m_res);
        check("y_out", obs_y, m_y);
        check("nzvc", 64'(obs_flags), 64'(m_fl));
        check("illegal", 64'(obs_ill), 64'(ill));
        check("ready_at_done", 64'(obs_ready), 64'd1);
    endtask

    task automatic reset_model();
        m_res = '0;
        m_y   = '0;
        m_fl  = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(obs_ready), 64'd1);
        check({tag, "_done"}, 64'(obs_done), 64'd0);
        check({tag, "_ill"}, 64'(obs_ill), 64'd0);
        check({tag, "_result"}, obs_res, 64'd0);
        check({tag, "_y"}, obs_y, 64'd0);
        check({tag, "_nzvc"}, 64'(obs_flags), 64'd0);
    endtask

    task automatic random_ops(input int count);
        for (int k = 0; k < count; k++) begin
            do_op(pick_op(), pick_val(w), pick_val(w), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                @(negedge clk);
                check("done_pulse", 64'(obs_done), 64'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ndone;
        rst       = 1'b1;
        sel       = 1'b0;
        w         = 32;
        mul_en    = 1'b1;
        drv_start = 1'b0;
        drv_op    = '0;
        drv_a     = '0;
        drv_b     = '0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        do_op(6'b010000, 64'h7FFFFFFF, 64'h00000001, 1'b0);
        check("add_ovf_res", obs_res, 64'h80000000);
        check("add_ovf_nzvc", 64'(obs_flags), 64'b1010);
        check("add_ovf_lat", 64'(last_lat), 64'd2);
        do_op(6'b010100, 64'h0, 64'h1, 1'b0);
        check("sub_borrow_res", obs_res, 64'hFFFFFFFF);
        check("sub_borrow_nzvc", 64'(obs_flags), 64'b1001);
        do_op(6'b011100, 64'h5, 64'h2, 1'b0);
        check("subx_res", obs_res, 64'h2);
        do_op(6'b100111, 64'h80000000, 64'h3F, 1'b1);
        check("sra_res", obs_res, 64'hFFFFFFFF);
        check("sra_nzvc", 64'(obs_flags), 64'b0000);
        do_op(6'b100101, 64'h12345678, 64'h20, 1'b1);
        check("sll_amt0_res", obs_res, 64'h12345678);
        do_op(6'b011011, 64'hFFFFFFFE, 64'h3, 1'b1);
        check("smul_res", obs_res, 64'hFFFFFFFA);
        check("smul_y", obs_y, 64'hFFFFFFFF);
        check("smul_nzvc", 64'(obs_flags), 64'b1000);
        check("smul_lat", 64'(last_lat), 64'd33);

        // Abort a multiply in its tenth cycle; start on the reset edge must lose.
        drv_start = 1'b1;
        drv_op    = 6'b011011;
        drv_a     = 64'h1234;
        drv_b     = 64'h5678;
        @(posedge clk);
        @(negedge clk);
        drv_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mul_busy", 64'(obs_ready), 64'd0);
        rst       = 1'b1;
        drv_start = 1'b1;
        drv_op    = 6'b010000;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        drv_start = 1'b0;
        reset_model();
        check_reset_state("abort");
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (obs_done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        do_op(6'b111111, 64'hDEAD, 64'hBEEF, 1'b0);
        check("illegal_res", obs_res, 64'd0);
        check("illegal_flag", 64'(obs_ill), 64'd1);

        random_ops(150);

        // Narrow instance without the multiplier.
        sel    = 1'b1;
        w      = 8;
        mul_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        check_reset_state("reset8");
        do_op(6'b010000, 64'hFF, 64'h01, 1'b0);
        check("add8_res", obs_res, 64'h00);
        check("add8_nzvc", 64'(obs_flags), 64'b0101);
        do_op(6'b001010, 64'h12, 64'h34, 1'b1);
        check("umul8_illegal", 64'(obs_ill), 64'd1);
        check("umul8_lat", 64'(last_lat), 64'd2);
        random_ops(60);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter MUL_EN, default 1, enables the iterative multiply opcodes; when 0 they are treated as illegal.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; accepted only on a cycle where ready=1.
REQ-006 opcode  input  6  operation select; bit 4 is the S (set condition codes) bit.
REQ-007 a_in, b_in  input  WIDTH  operands; sampled on the accept cycle only.
REQ-008 ready  output  1  high when in IDLE and able to accept start.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  WIDTH  registered result; holds until the next done.
REQ-011 y_out  output  WIDTH  registered upper half of the last multiply product.
REQ-012 n, z, v, c  output  1 each  registered condition codes.
REQ-013 illegal  output  1  pulses with done when opcode is unsupported.

Function
REQ-014 The FSM shall have states IDLE, EXEC and MUL; ready=1 only in IDLE.
REQ-015 IDLE+start shall latch opcode/a_in/b_in and go to EXEC, or to MUL for multiply opcodes with MUL_EN=1.
REQ-016 EXEC shall complete in one cycle: result/flags/done update on the edge leaving EXEC, then IDLE (latency 2 clocks start->done).
REQ-017 Opcodes (S=0 / S=1): ADD 000000/010000, ADDX 001000/011000, SUB 000100/010100, SUBX 001100/011100, AND 000001/010001, ANDN 000101/010101, OR 000010/010010, ORN 000110/010110, XOR 000011/010011, XNOR 000111/010111.
REQ-018 ANDN/ORN/XNOR shall compute a&~b, a|~b, ~(a^b).
REQ-019 Shifts SLL 100101, SRL 100110, SRA 100111 shall use only b[log2(WIDTH)-1:0] as the amount; SRA shall replicate a[WIDTH-1]; shifts never alter flags.
REQ-020 SETHI 101010 shall produce {b[WIDTH-11:0],10'b0}; flags unchanged.
REQ-021 ADDX shall add the registered c flag; SUBX shall compute a-b-c (c as borrow).
REQ-022 Arithmetic is computed WIDTH+1 bits wide; add C = carry out; sub C = borrow (1 when unsigned a < b + cin).
REQ-023 Add V = operands same sign and result sign differs; sub V = operand signs differ and result sign differs from a.
REQ-024 Logical S-ops shall set N=result MSB, Z=(result==0), V=0, C=0.
REQ-025 Flags shall update only at done and only when opcode[4]=1; otherwise hold.
REQ-026 UMUL 001010/011010 and SMUL 001011/011011 shall use a shift-add loop of exactly WIDTH MUL cycles, done on the last; latency WIDTH+1 clocks start->done.
REQ-027 SMUL shall produce the two's-complement 2*WIDTH product; low half -> result, high half -> y_out.
REQ-028 Multiply with S shall set N/Z from the low half, V=0, C=0.
REQ-029 y_out shall change only on multiply completion.
REQ-030 Unsupported opcodes shall complete via EXEC with result=0, illegal=1, flags and y_out unchanged.
REQ-031 start while ready=0 shall be ignored, with no queuing.
REQ-032 Operand input changes after acceptance shall not affect the operation in flight.
REQ-033 start may be reasserted in the cycle done is high; it is accepted since the FSM is in IDLE.

Reset
REQ-034 On rst=1 at a clock edge: state=IDLE, result=0, y_out=0, n=z=v=c=0, done=0, illegal=0; ready=1 the next cycle.
REQ-035 rst asserted during EXEC or MUL shall abort the operation, with no done pulse and no flag or y_out update.
REQ-036 rst shall take priority over start on the same edge.

Verification
REQ-037 WIDTH=32, ADD S: a=7FFFFFFF, b=00000001 -> 2 clocks later done, result=80000000, N=1 Z=0 V=1 C=0.
REQ-038 SUB S: a=0, b=1 -> result=FFFFFFFF, N=1 Z=0 V=0 C=1; then SUBX S a=5, b=2 -> result=2.
REQ-039 SRA: a=80000000, b=0000003F -> result=FFFFFFFF (amount 31), flags unchanged; SLL with b=20 -> amount 0, result=a.
REQ-040 SMUL S: a=FFFFFFFE, b=00000003 -> done 33 clocks after start, result=FFFFFFFA, y_out=FFFFFFFF, N=1 Z=0 V=0 C=0; start pulses during MUL ignored.
REQ-041 Reset mid-MUL at cycle 10 -> no done, flags/y_out keep prior values zeroed by reset, ready=1 next cycle; opcode 111111 -> result=0, illegal=1.
REQ-042 WIDTH=8, MUL_EN=0: ADD S a=FF, b=01 -> result=00, Z=1 C=1; UMUL -> illegal=1 after 2 clocks.
